// File: rtl/isa_test_monitor_pkg.sv
// Shared constants, state encoding and outcome classification for the ISA test monitor.
// The default addresses and codes must match the test linker script.
package isa_test_monitor_pkg;

  localparam logic [1:0] ST_PASS    = 2'd0;
  localparam logic [1:0] ST_FAIL    = 2'd1;
  localparam logic [1:0] ST_ERROR   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam logic [29:0] DEF_TOHOST_ADDR  = 30'h3f0;
  localparam logic [29:0] DEF_CONSOLE_ADDR = 30'h3f1;
  localparam logic [31:0] DEF_PASS_CODE    = 32'h55;
  localparam logic [31:0] DEF_FAIL_CODE    = 32'haa;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  function automatic logic [1:0] classify(input logic [31:0] value,
                                          input logic [31:0] pass_code,
                                          input logic [31:0] fail_code);
    if (value == pass_code) return ST_PASS;
    if (value == fail_code) return ST_FAIL;
    return ST_ERROR;
  endfunction

endpackage

// File: rtl/isa_test_monitor_sync_fifo.sv
// Reusable synchronous FIFO. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; dout reads the head and is zero when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/isa_test_monitor.sv
// End-of-test monitor: snoops the cpu-to-ram bus, decides PASS/FAIL/ERROR/TIMEOUT
// and buffers console bytes for draining over a valid/ready port.
module isa_test_monitor
  import isa_test_monitor_pkg::*;
#(
  parameter logic [29:0] TOHOST_ADDR  = DEF_TOHOST_ADDR,
  parameter logic [29:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_CODE    = DEF_PASS_CODE,
  parameter logic [31:0] FAIL_CODE    = DEF_FAIL_CODE,
  parameter int          TIMEOUT      = 10000,
  parameter int          CYCLE_W      = 32,
  parameter int          CON_DEPTH    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [29:0]        addr,
  input  logic [31:0]        wdata,
  input  logic [3:0]         we,
  input  logic               halt,
  input  logic [31:0]        result,
  output logic               done,
  output logic [1:0]         status,
  output logic [31:0]        code,
  output logic [CYCLE_W-1:0] cycles,
  output logic               con_valid,
  output logic [7:0]         con_data,
  input  logic               con_ready,
  output logic               con_overflow
);

  state_t             state_reg, state_next;
  logic [1:0]         status_reg, status_next;
  logic [31:0]        code_reg, code_next;
  logic [CYCLE_W-1:0] cycles_reg, cycles_next;
  logic               con_overflow_reg;

  logic tohost_hit;
  logic timeout_hit;
  logic con_push;
  logic con_pop;
  logic con_full;
  logic con_empty;

  assign tohost_hit  = (addr == TOHOST_ADDR) && (we == 4'b1111);
  assign timeout_hit = (cycles_reg == CYCLE_W'(TIMEOUT - 1));
  assign con_push    = (state_reg == S_RUN) && (addr == CONSOLE_ADDR) && we[0];
  assign con_pop     = con_valid && con_ready;

  always_comb begin
    state_next  = state_reg;
    status_next = status_reg;
    code_next   = code_reg;
    cycles_next = cycles_reg;
    if (state_reg == S_RUN) begin
      cycles_next = cycles_reg + CYCLE_W'(1);
      if (tohost_hit) begin
        state_next  = S_DONE;
        code_next   = wdata;
        status_next = classify(wdata, PASS_CODE, FAIL_CODE);
      end else if (halt) begin
        state_next  = S_DONE;
        code_next   = result;
        status_next = classify(result, PASS_CODE, FAIL_CODE);
      end else if (timeout_hit) begin
        state_next  = S_DONE;
        code_next   = '0;
        status_next = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_RUN;
      status_reg <= ST_PASS;
      code_reg   <= '0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      status_reg <= status_next;
      code_reg   <= code_next;
      cycles_reg <= cycles_next;
    end
  end

  // A byte is lost only when the FIFO is full and nothing leaves it this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      con_overflow_reg <= 1'b0;
    end else if (con_push && con_full && !con_pop) begin
      con_overflow_reg <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(CON_DEPTH)
  ) u_con_fifo (
    .clk  (clk),
    .reset(reset),
    .push (con_push),
    .pop  (con_pop),
    .din  (wdata[7:0]),
    .dout (con_data),
    .full (con_full),
    .empty(con_empty)
  );

  assign done         = (state_reg == S_DONE);
  assign status       = status_reg;
  assign code         = code_reg;
  assign cycles       = cycles_reg;
  assign con_valid    = !con_empty;
  assign con_overflow = con_overflow_reg;

endmodule

// File: tb/tb_isa_test_monitor.sv
// Directed bench for isa_test_monitor: outcome decode, priority, timeout and console FIFO.
module tb_isa_test_monitor;
  import isa_test_monitor_pkg::*;

  logic        clk;
  logic        reset;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        halt;
  logic [31:0] result;
  logic        done;
  logic [1:0]  status;
  logic [31:0] code;
  logic [31:0] cycles;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic        con_overflow;

  int checks = 0;
  int errors = 0;

  isa_test_monitor #(
    .TIMEOUT  (100),
    .CYCLE_W  (32),
    .CON_DEPTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .we          (we),
    .halt        (halt),
    .result      (result),
    .done        (done),
    .status      (status),
    .code        (code),
    .cycles      (cycles),
    .con_valid   (con_valid),
    .con_data    (con_data),
    .con_ready   (con_ready),
    .con_overflow(con_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
    $display("check %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic idle_bus();
    addr = 30'h0; wdata = 32'h0; we = 4'h0; halt = 1'b0; result = 32'h0;
  endtask

  task automatic con_write(input logic [7:0] b);
    addr = DEF_CONSOLE_ADDR; wdata = {24'h0, b}; we = 4'h1;
    step();
    idle_bus();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_status"}, {30'b0, status}, 32'd0);
    chk({tag, "_code"}, code, 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
    chk({tag, "_con_valid"}, {31'b0, con_valid}, 32'd0);
    chk({tag, "_con_data"}, {24'b0, con_data}, 32'd0);
    chk({tag, "_con_overflow"}, {31'b0, con_overflow}, 32'd0);
  endtask

  logic [7:0] hello [5];

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4c; hello[3] = 8'h4c; hello[4] = 8'h4f;
    reset = 1'b0; con_ready = 1'b0;
    idle_bus();
    #2;
    do_reset();
    chk_reset_state("reset");

    // 1: tohost PASS write on the 40th cycle
    repeat (39) step();
    chk("t1_not_done", {31'b0, done}, 32'd0);
    addr = DEF_TOHOST_ADDR; wdata = 32'h55; we = 4'hf;
    step();
    idle_bus();
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_status", {30'b0, status}, 32'd0);
    chk("t1_code", code, 32'h55);
    chk("t1_cycles", cycles, 32'd40);
    repeat (3) step();
    chk("t1_cycles_frozen", cycles, 32'd40);

    // 2: halt with FAIL code, then with an unknown code
    do_reset();
    repeat (24) step();
    halt = 1'b1; result = 32'haa;
    step();
    idle_bus();
    chk("t2_done", {31'b0, done}, 32'd1);
    chk("t2_status", {30'b0, status}, 32'd1);
    chk("t2_code", code, 32'haa);
    chk("t2_cycles", cycles, 32'd25);
    do_reset();
    repeat (24) step();
    halt = 1'b1; result = 32'h7;
    step();
    idle_bus();
    chk("t2b_status", {30'b0, status}, 32'd2);
    chk("t2b_code", code, 32'h7);

    // 3: timeout after 100 edges
    do_reset();
    repeat (99) step();
    chk("t3_not_done", {31'b0, done}, 32'd0);
    chk("t3_cycles99", cycles, 32'd99);
    step();
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_status", {30'b0, status}, 32'd3);
    chk("t3_code", code, 32'd0);
    chk("t3_cycles", cycles, 32'd100);

    // 4: partial tohost write ignored; tohost beats halt in the same cycle
    do_reset();
    addr = DEF_TOHOST_ADDR; wdata = 32'h55; we = 4'h1;
    step();
    idle_bus();
    chk("t4_partial_ignored", {31'b0, done}, 32'd0);
    addr = DEF_TOHOST_ADDR; wdata = 32'h55; we = 4'hf; halt = 1'b1; result = 32'haa;
    step();
    idle_bus();
    chk("t4_done", {31'b0, done}, 32'd1);
    chk("t4_status", {30'b0, status}, 32'd0);
    chk("t4_code", code, 32'h55);
    halt = 1'b1; result = 32'h7;
    step();
    idle_bus();
    chk("t4_halt_ignored_in_done", code, 32'h55);
    chk("t4_cycles_hold", cycles, 32'd2);

    // 5: console buffering, in-order drain, overflow, push-while-full-with-pop
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 5; i++) con_write(hello[i]);
    repeat (2) step();
    chk("t5_buffered_valid", {31'b0, con_valid}, 32'd1);
    chk("t5_buffered_head", {24'b0, con_data}, 32'h48);
    con_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_drain%0d", i), {24'b0, con_data}, {24'b0, hello[i]});
      step();
    end
    chk("t5_drained_empty", {31'b0, con_valid}, 32'd0);
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) con_write(8'h30 + 8'(i));
    chk("t5_full_no_overflow", {31'b0, con_overflow}, 32'd0);
    con_write(8'h38);
    chk("t5_overflow", {31'b0, con_overflow}, 32'd1);
    chk("t5_head_after_drop", {24'b0, con_data}, 32'h30);
    con_ready = 1'b1;
    con_write(8'hab);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("t5_full_drain%0d", i), {24'b0, con_data}, 32'h30 + i);
      step();
    end
    chk("t5_pushed_while_full", {24'b0, con_data}, 32'hab);
    step();
    chk("t5_empty_end", {31'b0, con_valid}, 32'd0);
    con_ready = 1'b0;

    // 6: reset mid-run with bytes queued
    do_reset();
    for (int i = 0; i < 3; i++) con_write(8'h61 + 8'(i));
    repeat (2) step();
    chk("t6_queued", {31'b0, con_valid}, 32'd1);
    do_reset();
    chk_reset_state("t6");
    step();
    chk("t6_cycles_restart", cycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
